// File: rtl/uart_tx_if.sv
// uart_tx_if: valid/ready byte handshake into the UART transmitter
interface uart_tx_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  modport master (output tx_valid, tx_data, input tx_ready);
  modport slave (input tx_valid, tx_data, output tx_ready);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter with byte FIFO; parity bit optional via UART_TX_PARITY_EN
module uart_tx #(
  parameter int CLK_FREQ   = 15360000,
  parameter int BAUD       = 614400,
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_tx_if.slave bus,
  output logic     tx,
  output logic     tx_busy,
  output logic     tx_done,
  output logic     tx_empty
);
  localparam int DIV = CLK_FREQ / BAUD;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(STOP_BITS * DIV);
  localparam logic [CW-1:0] BIT_LD  = CW'(DIV - 1);
  localparam logic [CW-1:0] STOP_LD = CW'(STOP_BITS * DIV - 1);
  localparam logic [AW:0]   FULL    = (AW+1)'(FIFO_DEPTH);
  if (DIV < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
    $error("uart_tx: invalid parameter set");
  end
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop, fifo_empty;
  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0]    shift, shift_n;
  logic [2:0]    idx, idx_n;
  logic          tx_n, done_n;
`ifdef UART_TX_PARITY_EN
  logic          par, par_n;
`endif
  assign fifo_empty   = count == '0;
  assign bus.tx_ready = count != FULL;
  assign push         = bus.tx_valid && bus.tx_ready;
  assign tx_busy      = state != IDLE;
  assign tx_empty     = !tx_busy && fifo_empty;
  // FIFO storage, written only on an accepted push
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= bus.tx_data;
  // FIFO pointers and occupancy; push and pop in one cycle leave count unchanged
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  // next-state logic: baud countdown, bit sequencing and FIFO pop at frame start
  always_comb begin
    state_n = state;
    shift_n = shift;
    idx_n   = idx;
    pop     = 1'b0;
    cnt_n   = (state == IDLE || cnt == '0) ? cnt : cnt - CW'(1);
`ifdef UART_TX_PARITY_EN
    par_n   = par;
`endif
    case (state)
      IDLE:
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_n = START;
          cnt_n   = BIT_LD;
        end
      START:
        if (cnt == '0) begin
          state_n = DATA;
          idx_n   = '0;
          cnt_n   = BIT_LD;
        end
      DATA:
        if (cnt == '0) begin
          shift_n = shift >> 1;
          idx_n   = idx + 3'd1;
          cnt_n   = BIT_LD;
          if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
            cnt_n   = STOP_LD;
`endif
          end
        end
`ifdef UART_TX_PARITY_EN
      PARITY:
        if (cnt == '0) begin
          state_n = STOP;
          cnt_n   = STOP_LD;
        end
`endif
      STOP:
        if (cnt == '0) begin
          state_n = IDLE;
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_n = START;
            cnt_n   = BIT_LD;
          end
        end
      default: state_n = IDLE;
    endcase
    if (pop) begin
      shift_n = mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
      par_n   = ^mem[rd_ptr] ^ (PARITY_ODD != 0);
`endif
    end
`ifdef UART_TX_PARITY_EN
    tx_n = state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] : state_n == PARITY ? par_n : 1'b1;
`else
    tx_n = state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] : 1'b1;
`endif
    done_n = state_n == STOP && cnt_n == '0;
  end
  // state register; tx and tx_done come straight from flops so the line never glitches
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      shift   <= '0;
      idx     <= '0;
      tx      <= 1'b1;
      tx_done <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      shift   <= shift_n;
      idx     <= idx_n;
      tx      <= tx_n;
      tx_done <= done_n;
    end
`ifdef UART_TX_PARITY_EN
  // parity of the byte being sent, captured when it leaves the FIFO
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) par <= 1'b0;
    else par <= par_n;
`endif
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx (default and 2-stop-bit instances)
module tb_uart_tx;
  localparam int DIV   = 25;
  localparam int LIMIT = 3000;
  localparam logic ODD0 = 1'b0;
  localparam logic ODD1 = 1'b1;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  typedef struct {
    logic [7:0] d;
    logic [9:0] f;
    logic       pe;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tx0, busy0, done0, empty0, tx1, busy1, done1, empty1;
  int cyc = 0, nd0 = 0, nd1 = 0, passed = 0, total = 0;
  vec_t tbl[7];
  int ta[10], st[10], wt[10];
  logic [7:0] q[$];
  uart_tx_if i0();
  uart_tx_if i1();
  uart_tx u0 (.clk(clk), .rst_n(rst_n), .bus(i0), .tx(tx0), .tx_busy(busy0), .tx_done(done0), .tx_empty(empty0));
  uart_tx #(.STOP_BITS(2), .PARITY_ODD(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(i1), .tx(tx1), .tx_busy(busy1), .tx_done(done1), .tx_empty(empty1));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (done0) nd0 <= nd0 + 1;
    if (done1) nd1 <= nd1 + 1;
  end
  function automatic int flen(input int stop);
    return (9 + PB + stop) * DIV;
  endfunction
  function automatic logic txs(input int sel);
    return sel != 0 ? tx1 : tx0;
  endfunction
  function automatic logic dones(input int sel);
    return sel != 0 ? done1 : done0;
  endfunction
  function automatic logic rdy(input int sel);
    return sel != 0 ? i1.tx_ready : i0.tx_ready;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, wanted %0h", nm, act, exp);
  endtask
  task automatic drive(input int sel, input logic v, input logic [7:0] d);
    if (sel != 0) begin
      i1.tx_valid = v;
      i1.tx_data  = d;
    end else begin
      i0.tx_valid = v;
      i0.tx_data  = d;
    end
  endtask
  // offers d from a negedge and returns at the negedge after the accepting edge
  task automatic push(input int sel, input logic [7:0] d, output int t, output int waited);
    int n = 0;
    drive(sel, 1'b1, d);
    while (!rdy(sel) && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (n >= LIMIT) begin
      chk("push timeout", 32'(rdy(sel)), 1);
      t = -1;
    end else begin
      @(negedge clk);
      t = cyc;
    end
    waited = n;
  endtask
  task automatic wait_start(input int sel, input string nm, output int t);
    int n = 0;
    while (txs(sel) !== 1'b0 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (n >= LIMIT) chk({nm, " start timeout"}, 32'(txs(sel)), 0);
    t = cyc;
  endtask
  // compares every line cycle of one frame (first sample = first low cycle) and the done pulse
  task automatic check_frame(input int sel, input string nm, input logic [9:0] f, input logic par, input int stop);
    int bad = 0;
    int len = flen(stop);
    int bi;
    logic e;
    for (int k = 0; k < len; k++) begin
      if (k > 0) @(negedge clk);
      bi = k / DIV;
      e = bi < 9 ? f[bi] : (PB == 1 && bi == 9) ? par : 1'b1;
      if (txs(sel) !== e) bad++;
      if (dones(sel) !== (k == len - 1)) bad++;
    end
    chk({nm, " frame errors"}, bad, 0);
  endtask
  task automatic watch_q(input int sel, input string nm, input int stop, input logic odd, output int t);
    logic [7:0] d;
    wait_start(sel, nm, t);
    if (q.size() == 0) chk({nm, " unexpected frame"}, q.size(), 1);
    else begin
      d = q.pop_front();
      check_frame(sel, nm, {1'b1, d, 1'b0}, ^d ^ odd, stop);
    end
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
  initial begin
    int t0, ts, w, d0, low;
    logic [7:0] base, rd;
    tbl[0] = '{8'h55, 10'h2AA, 1'b0};
    tbl[1] = '{8'h00, 10'h200, 1'b0};
    tbl[2] = '{8'hFF, 10'h3FE, 1'b0};
    tbl[3] = '{8'hA5, 10'h34A, 1'b0};
    tbl[4] = '{8'h3C, 10'h278, 1'b0};
    tbl[5] = '{8'h01, 10'h202, 1'b1};
    tbl[6] = '{8'h07, 10'h20E, 1'b1};
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    chk("rst tx", 32'(tx0), 1);
    chk("rst ready", 32'(i0.tx_ready), 1);
    chk("rst busy", 32'(busy0), 0);
    chk("rst done", 32'(done0), 0);
    chk("rst empty", 32'(empty0), 1);
    chk("rst tx u1", 32'(tx1), 1);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      fork
        begin
          push(0, tbl[i].d, t0, w);
          drive(0, 1'b0, 8'h00);
        end
        wait_start(0, "tbl", ts);
      join
      chk($sformatf("tbl%0d latency", i), ts - t0, 1);
      check_frame(0, $sformatf("tbl%0d", i), tbl[i].f, tbl[i].pe ^ ODD0, 1);
      @(negedge clk);
      chk($sformatf("tbl%0d empty", i), 32'(empty0), 1);
    end
    d0 = nd0;
    fork
      begin
        for (int i = 0; i < 4; i++) push(0, 8'(i + 1), ta[i], wt[i]);
        drive(0, 1'b0, 8'h00);
      end
      for (int i = 0; i < 4; i++) begin
        wait_start(0, "b2b", st[i]);
        check_frame(0, "b2b", {1'b1, 8'(i + 1), 1'b0}, ^(8'(i + 1)) ^ ODD0, 1);
      end
    join
    @(negedge clk);
    chk("b2b accepted back to back", ta[3] - ta[0], 3);
    chk("b2b contiguous", st[3] - st[0], 3 * flen(1));
    chk("b2b done count", nd0 - d0, 4);
    chk("b2b empty", 32'(empty0), 1);
    base = 8'($urandom);
    q.delete();
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          push(0, 8'(base + i * 37), ta[i], wt[i]);
          q.push_back(8'(base + i * 37));
        end
        drive(0, 1'b0, 8'h00);
      end
      for (int i = 0; i < 6; i++) watch_q(0, "hold", 1, ODD0, st[i]);
    join
    chk("hold burst accepted", ta[4] - ta[0], 4);
    chk("hold byte6 stalled", 32'(wt[5] > 0), 1);
    chk("hold byte6 resume", ta[5], st[1] + 1);
    chk("hold queue drained", q.size(), 0);
    @(negedge clk);
    d0 = nd0;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          rd = 8'($urandom);
          push(0, rd, ta[i], wt[i]);
          q.push_back(rd);
          drive(0, 1'b0, 8'h00);
          repeat ($urandom_range(0, 300)) @(negedge clk);
        end
      end
      for (int i = 0; i < 10; i++) watch_q(0, "rand", 1, ODD0, st[i]);
    join
    @(negedge clk);
    chk("rand done count", nd0 - d0, 10);
    chk("rand queue drained", q.size(), 0);
    fork
      begin
        push(1, 8'hFF, t0, w);
        drive(1, 1'b0, 8'h00);
      end
      wait_start(1, "stop2", ts);
    join
    chk("stop2 latency", ts - t0, 1);
    check_frame(1, "stop2", 10'h3FE, 1'b0 ^ ODD1, 2);
    @(negedge clk);
    chk("stop2 empty", 32'(empty1), 1);
`ifdef UART_TX_PARITY_EN
    fork
      begin
        push(1, 8'h07, t0, w);
        drive(1, 1'b0, 8'h00);
      end
      wait_start(1, "odd07", ts);
    join
    check_frame(1, "odd07", 10'h20E, 1'b0, 2);
    @(negedge clk);
`endif
    fork
      begin
        push(0, 8'h00, t0, w);
        push(0, 8'h11, ta[0], w);
        push(0, 8'h22, ta[1], w);
        drive(0, 1'b0, 8'h00);
      end
      wait_start(0, "rst", ts);
    join
    while (cyc < ts + 4 * DIV + 12) @(negedge clk);
    chk("pre-reset bit3 low", 32'(tx0), 0);
    d0 = nd0;
    #2 rst_n = 1'b0;
    #1 chk("reset async tx", 32'(tx0), 1);
    repeat (3) @(negedge clk);
    chk("reset held tx", 32'(tx0), 1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset empty", 32'(empty0), 1);
    chk("post-reset ready", 32'(i0.tx_ready), 1);
    chk("post-reset busy", 32'(busy0), 0);
    low = 0;
    repeat (3 * flen(1)) begin
      @(negedge clk);
      if (tx0 !== 1'b1) low++;
    end
    chk("no frames after reset", low, 0);
    chk("no done across reset", nd0 - d0, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
